false_lock_detector: RTL and testbench
======================================

# false_lock_detector

Carrier-loop false-lock detector sitting directly downstream of the demod register bank. It consumes the `falseLockAlpha`/`falseLockThreshold` controls and `demodLock`, tracks an exponentially averaged magnitude of the carrier-loop frequency estimate, and qualifies it with hysteresis and dwell counting. It returns `highFreqOffset` to the register bank's `DEMOD_STATUS` and issues a one-clock `falseLockReset` pulse to the carrier-loop integrator when the loop reports lock at an implausible offset.

## Interface
- `HOLD_COUNT`, 256: consecutive enabled samples required to enter or leave the offset state (1..65535).
- `HOLDOFF`, 1024: enabled samples after a `falseLockReset` during which no new reset is issued (1..65535).
- `clk` in 1: system clock.
- `reset` in 1: reset, asynchronous, active-high.
- `clkEn` in 1: sample strobe; `freqIn` is valid on cycles where this is high.
- `freqIn` in 12: signed two's-complement carrier-loop frequency estimate.
- `demodLock` in 1: carrier-loop lock indication.
- `falseLockAlpha` in 16: averaging gain, unsigned, gain = alpha/65536.
- `falseLockThreshold` in 16: unsigned offset threshold, same scale as `avgMag`.
- `avgMag` out 16: averaged magnitude.
- `highFreqOffset` out 1: qualified high-offset status.
- `falseLockReset` out 1: one-clk pulse to the loop integrator.

## Operation
- `falseLockAlpha` and `falseLockThreshold` are quasi-static. Both are captured into local registers every `clk` and used from those registers.
- Magnitude: `mag = |freqIn|`. Input −2048 saturates to 2047. `mag16 = mag << 4`, unsigned 16 bits, max 32752.
- Averager, on each `clkEn`:
  - `e = mag16 − avgMag`, signed 17 bits.
  - `p = e × alpha`, signed 33 bits.
  - `d = p >>> 16`, arithmetic shift, floor.
  - `avgMag <= clamp(avgMag + d, 0, 65535)`.
  - alpha = 0 freezes `avgMag`.
- Low threshold: `thrLo = thr − (thr >> 3)`, 16 bits.
- Comparisons use the pre-update (registered) `avgMag` on the same `clkEn` cycle.
- FSM, advancing only on `clkEn` cycles:
  - NORMAL (`highFreqOffset` = 0): `avgMag > thr` → RISING, `cnt` = 1.
  - RISING: `avgMag > thr` → `cnt++`; when `cnt` reaches `HOLD_COUNT` → OFFSET. Any sample with `avgMag <= thr` → NORMAL, `cnt` = 0.
  - OFFSET (`highFreqOffset` = 1): `avgMag < thrLo` → FALLING, `cnt` = 1.
  - FALLING: `avgMag < thrLo` → `cnt++`; when `cnt` reaches `HOLD_COUNT` → NORMAL. Any sample with `avgMag >= thrLo` → OFFSET, `cnt` = 0.
  - `HOLD_COUNT` = 1 means transition on the first qualifying sample.
- `highFreqOffset` is 1 in OFFSET and FALLING, 0 in NORMAL and RISING.
- False-lock reset: on a `clkEn` cycle where `highFreqOffset` = 1, `demodLock` = 1 and `holdoffCnt` = 0:
  - `falseLockReset` = 1 for exactly one `clk`.
  - `holdoffCnt <= HOLDOFF`.
  - `holdoffCnt` decrements on each subsequent `clkEn` until it reaches 0.
- Threshold = 0: OFFSET is entered whenever `avgMag` > 0 for the dwell. `thrLo` = 0, so OFFSET is never exited. This is required behaviour: it is the documented "force offset" setting.
- Changing threshold mid-dwell does not clear `cnt`. Each sample is judged against the current threshold.

## Timing
- Reset values:
  - `avgMag` = 0, `highFreqOffset` = 0, `falseLockReset` = 0.
  - State NORMAL, `cnt` = 0, `holdoffCnt` = 0.
  - Local alpha/threshold registers = 0.
- Register capture: `falseLockAlpha`/`falseLockThreshold` change → local copy 1 `clk` later.
- `avgMag` updates 1 `clk` after the `clkEn` cycle; it is a registered output.
- `highFreqOffset` is registered. It changes on the `clk` edge ending the `clkEn` cycle that completes the dwell.
- `falseLockReset` is registered. It is high on the cycle after the qualifying `clkEn` and independent of `clkEn` thereafter.
- With `clkEn` tied high, a step to a large offset with alpha = 65535 reaches `highFreqOffset` = 1 in `HOLD_COUNT` + 1 clks.
- `reset` asserted mid-dwell or mid-holdoff immediately forces every reset value. No pulse is emitted on release.
- Non-`clkEn` cycles: all state holds, `falseLockReset` is 0.

## Test plan
- Reset check: assert `reset` mid-operation with `avgMag` = 20000 and state OFFSET → all outputs 0 asynchronously, before the next `clk` edge.
- Averager step:
  - alpha = 0x8000, `freqIn` = 1000 constant, `clkEn` = 1 → `avgMag` = 8000, 12000, 14000, …, converging to 16000 ±1. The sequence is exact, floor arithmetic.
  - `freqIn` = −2048 → `mag16` = 32752.
- Dwell and hysteresis (`HOLD_COUNT` = 4, thr = 8000, `thrLo` = 7000):
  - `avgMag` held at 9000 → `highFreqOffset` rises after the 4th sample.
  - `avgMag` at 7500 → stays 1.
  - `avgMag` at 6900 for 4 samples → falls to 0.
  - A 3-sample excursion in either direction → no change.
- False-lock pulse (`HOLDOFF` = 8): `highFreqOffset` = 1, `demodLock` = 1 steady → `falseLockReset` pulses once every 9 `clkEn` samples, each pulse 1 clk wide. `demodLock` = 0 → no pulses.
- `clkEn` gating: `clkEn` toggling 1-in-4 with a `HOLD_COUNT` = 4 dwell → transition after 16 clks. State frozen between strobes.
- Zero settings:
  - alpha = 0 → `avgMag` frozen.
  - thr = 0, `freqIn` = 1 → OFFSET entered and never exited.

Source files
------------

// File: rtl/false_lock_detector.sv
// Carrier-loop false-lock detector: EMA of |freq|, hysteresis/dwell qualified offset status,
// and a holdoff-limited one-clock reset pulse to the loop integrator when lock is implausible.
module false_lock_detector #(
  parameter int HOLD_COUNT = 256,
  parameter int HOLDOFF    = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clkEn,
  input  logic [11:0] freqIn,
  input  logic        demodLock,
  input  logic [15:0] falseLockAlpha,
  input  logic [15:0] falseLockThreshold,
  output logic [15:0] avgMag,
  output logic        highFreqOffset,
  output logic        falseLockReset
);

  localparam logic [15:0] HOLD  = 16'(HOLD_COUNT);
  localparam logic [15:0] HOFF  = 16'(HOLDOFF);

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    RISING  = 2'd1,
    OFFSET  = 2'd2,
    FALLING = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [15:0] holdoff_cnt;
  logic [15:0] alpha_q, thr_q;
  logic [15:0] thr_lo;

  logic [11:0]        neg;
  logic [10:0]        mag;
  logic [15:0]        mag16;
  logic signed [16:0] err;
  logic signed [33:0] prod;
  logic signed [17:0] delta;
  logic signed [18:0] sum;
  logic [15:0]        avg_nxt;
  logic               above, below, cnt_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alpha_q <= 16'd0;
      thr_q   <= 16'd0;
    end else begin
      alpha_q <= falseLockAlpha;
      thr_q   <= falseLockThreshold;
    end
  end

  // |freqIn| with -2048 saturating to 2047 so mag fits in 11 bits
  always_comb begin
    neg = ~freqIn + 12'd1;
    mag = freqIn[10:0];
    if (freqIn[11]) begin
      if (freqIn == 12'h800) mag = 11'd2047;
      else                   mag = neg[10:0];
    end
  end

  always_comb begin
    mag16 = {1'b0, mag, 4'b0000};
    err   = $signed({1'b0, mag16}) - $signed({1'b0, avgMag});
    prod  = err * $signed({1'b0, alpha_q});
    delta = prod[33:16];
    sum   = $signed({3'b000, avgMag}) + 19'(delta);
    if (sum < 0)
      avg_nxt = 16'd0;
    else if (sum > 19'sd65535)
      avg_nxt = 16'hFFFF;
    else
      avg_nxt = sum[15:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      avgMag <= 16'd0;
    else if (clkEn) avgMag <= avg_nxt;
  end

  assign thr_lo   = thr_q - (thr_q >> 3);
  assign above    = (avgMag > thr_q);
  assign below    = (avgMag < thr_lo);
  assign cnt_done = ((cnt + 16'd1) >= HOLD);

  // Dwell counting runs off the registered avgMag, i.e. the value before this sample's update
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (clkEn) begin
      case (state)
        NORMAL: begin
          if (above) begin
            if (HOLD <= 16'd1) begin
              state_nxt = OFFSET;
              cnt_nxt   = 16'd0;
            end else begin
              state_nxt = RISING;
              cnt_nxt   = 16'd1;
            end
          end
        end
        RISING: begin
          if (!above) begin
            state_nxt = NORMAL;
            cnt_nxt   = 16'd0;
          end else if (cnt_done) begin
            state_nxt = OFFSET;
            cnt_nxt   = 16'd0;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
        OFFSET: begin
          if (below) begin
            if (HOLD <= 16'd1) begin
              state_nxt = NORMAL;
              cnt_nxt   = 16'd0;
            end else begin
              state_nxt = FALLING;
              cnt_nxt   = 16'd1;
            end
          end
        end
        FALLING: begin
          if (!below) begin
            state_nxt = OFFSET;
            cnt_nxt   = 16'd0;
          end else if (cnt_done) begin
            state_nxt = NORMAL;
            cnt_nxt   = 16'd0;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
        default: begin
          state_nxt = NORMAL;
          cnt_nxt   = 16'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= NORMAL;
      cnt   <= 16'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign highFreqOffset = (state == OFFSET) || (state == FALLING);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      holdoff_cnt    <= 16'd0;
      falseLockReset <= 1'b0;
    end else begin
      falseLockReset <= 1'b0;
      if (clkEn) begin
        if (highFreqOffset && demodLock && (holdoff_cnt == 16'd0)) begin
          falseLockReset <= 1'b1;
          holdoff_cnt    <= HOFF;
        end else if (holdoff_cnt != 16'd0) begin
          holdoff_cnt <= holdoff_cnt - 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_false_lock_detector.sv
// Directed bench for false_lock_detector: averager arithmetic, dwell/hysteresis, gating,
// holdoff-limited pulses, async reset and zero-setting corner cases.
module tb_false_lock_detector;

  logic        clk = 1'b0;
  logic        reset;
  logic        clkEn;
  logic [11:0] freqIn;
  logic        demodLock;
  logic [15:0] falseLockAlpha;
  logic [15:0] falseLockThreshold;
  logic [15:0] avgMag;
  logic        highFreqOffset;
  logic        falseLockReset;

  int checks = 0;
  int errors = 0;
  int pulses;

  false_lock_detector #(.HOLD_COUNT(4), .HOLDOFF(8)) dut (
    .clk                (clk),
    .reset              (reset),
    .clkEn              (clkEn),
    .freqIn             (freqIn),
    .demodLock          (demodLock),
    .falseLockAlpha     (falseLockAlpha),
    .falseLockThreshold (falseLockThreshold),
    .avgMag             (avgMag),
    .highFreqOffset     (highFreqOffset),
    .falseLockReset     (falseLockReset)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; clkEn = 1'b0; freqIn = 12'd0; demodLock = 1'b0;
    falseLockAlpha = 16'd0; falseLockThreshold = 16'd0;
    #12;
    check("rst_avg", 32'(avgMag), 32'd0);
    check("rst_hfo", 32'(highFreqOffset), 32'd0);
    check("rst_flr", 32'(falseLockReset), 32'd0);
    tick();
    reset = 1'b0;

    // Averager step, alpha = 0.5, mag16 = 16000
    falseLockAlpha = 16'h8000; falseLockThreshold = 16'hFFFF; freqIn = 12'd1000;
    tick();
    check("avg_idle", 32'(avgMag), 32'd0);
    clkEn = 1'b1;
    tick(); check("avg_s1", 32'(avgMag), 32'd8000);
    tick(); check("avg_s2", 32'(avgMag), 32'd12000);
    tick(); check("avg_s3", 32'(avgMag), 32'd14000);
    tick(); check("avg_s4", 32'(avgMag), 32'd15000);
    for (int i = 0; i < 20; i++) tick();
    check("avg_conv", 32'(avgMag), 32'd15999);

    // -2048 saturates to mag16 = 32752; alpha 65535 lands one below from underneath
    clkEn = 1'b0; freqIn = 12'h800; falseLockAlpha = 16'hFFFF;
    tick();
    clkEn = 1'b1;
    tick(); check("avg_neg_full", 32'(avgMag), 32'd32751);

    // alpha = 0 freezes the average
    clkEn = 1'b0; falseLockAlpha = 16'd0;
    tick();
    clkEn = 1'b1; freqIn = 12'd0;
    for (int i = 0; i < 5; i++) tick();
    check("avg_frozen", 32'(avgMag), 32'd32751);

    // Dwell/hysteresis: thr 8000, thrLo 7000, 563->9008, 469->7504, 431->6896
    clkEn = 1'b0; falseLockAlpha = 16'hFFFF; falseLockThreshold = 16'd8000; freqIn = 12'd563;
    tick();
    clkEn = 1'b1;
    tick(); check("rise_avg", 32'(avgMag), 32'd9008);
    check("rise_s1", 32'(highFreqOffset), 32'd0);
    tick(); tick();
    check("rise_s3", 32'(highFreqOffset), 32'd0);
    tick(); check("rise_s4", 32'(highFreqOffset), 32'd1);

    freqIn = 12'd469;
    tick(); tick(); tick();
    check("band_avg", 32'(avgMag), 32'd7504);
    check("band_hfo", 32'(highFreqOffset), 32'd1);

    freqIn = 12'd431;
    tick(); tick(); tick();
    check("exc_dn_avg", 32'(avgMag), 32'd6896);
    freqIn = 12'd469;
    tick(); check("exc_dn_d", 32'(highFreqOffset), 32'd1);
    tick(); tick();
    check("exc_dn_end", 32'(highFreqOffset), 32'd1);

    freqIn = 12'd431;
    tick(); tick(); tick(); tick();
    check("fall_s3", 32'(highFreqOffset), 32'd1);
    tick(); check("fall_s4", 32'(highFreqOffset), 32'd0);

    freqIn = 12'd563;
    tick(); tick(); tick();
    freqIn = 12'd431;
    tick(); tick();
    check("exc_up_end", 32'(highFreqOffset), 32'd0);
    check("exc_up_avg", 32'(avgMag), 32'd6896);

    // clkEn 1-in-4: one warm-up strobe, then four strobes across 16 clks
    freqIn = 12'd563;
    tick();
    for (int i = 0; i < 16; i++) begin
      clkEn = (i % 4 == 3);
      tick();
      if (i == 13) check("gate_avg_hold", 32'(avgMag), 32'd9007);
      if (i == 14) check("gate_hfo_pre", 32'(highFreqOffset), 32'd0);
    end
    check("gate_hfo_post", 32'(highFreqOffset), 32'd1);

    // False-lock pulses once every 9 samples with HOLDOFF 8
    clkEn = 1'b1; demodLock = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("pulse_%0d", i), 32'(falseLockReset), (i % 9 == 0) ? 32'd1 : 32'd0);
    end
    demodLock = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (falseLockReset) pulses++;
    end
    check("nolock_pulses", 32'(pulses), 32'd0);

    // Build up avgMag 20000 in OFFSET with a pulse in flight, then reset mid-cycle
    freqIn = 12'd2047;
    tick();
    freqIn = 12'd1250;
    tick();
    check("pre_rst_avg", 32'(avgMag), 32'd20000);
    demodLock = 1'b1;
    tick();
    check("pre_rst_flr", 32'(falseLockReset), 32'd1);
    check("pre_rst_hfo", 32'(highFreqOffset), 32'd1);
    #3 reset = 1'b1;
    #1;
    check("async_avg", 32'(avgMag), 32'd0);
    check("async_hfo", 32'(highFreqOffset), 32'd0);
    check("async_flr", 32'(falseLockReset), 32'd0);
    tick();
    clkEn = 1'b0;
    reset = 1'b0;
    tick();
    check("release_flr", 32'(falseLockReset), 32'd0);
    check("release_hfo", 32'(highFreqOffset), 32'd0);

    // Threshold 0 forces OFFSET, never exited
    demodLock = 1'b0; falseLockAlpha = 16'hFFFF; falseLockThreshold = 16'd0; freqIn = 12'd1;
    tick();
    clkEn = 1'b1;
    tick(); check("z_avg_s1", 32'(avgMag), 32'd15);
    check("z_hfo_s1", 32'(highFreqOffset), 32'd0);
    tick(); tick(); tick();
    check("z_hfo_s4", 32'(highFreqOffset), 32'd0);
    tick(); check("z_hfo_s5", 32'(highFreqOffset), 32'd1);
    freqIn = 12'd0;
    for (int i = 0; i < 10; i++) tick();
    check("z_avg_end", 32'(avgMag), 32'd0);
    check("z_hfo_end", 32'(highFreqOffset), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
